data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 113 +++++++++++
 tb/tb_data_mem_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: multi-cycle single-word READ/WRITE with BUSYWAIT stall.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module data_mem_responder #(
    parameter int LATENCY   = 5,
    parameter int ADDR_BITS = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        MISALIGN
`endif
);

    // state  | meaning
    // IDLE   | waiting for READ/WRITE; BUSYWAIT follows the request
    // ACCESS | counting down the access latency, BUSYWAIT high
    // DONE   | access committed, BUSYWAIT low, request not re-accepted
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]           state;
    logic [7:0]           cnt;
    logic                 op_write;
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          wdata;
    logic [31:0]          mem [2**ADDR_BITS];
    logic                 req;
    logic                 accept;
    logic                 commit;
    logic                 misaligned;
    logic                 unused_addr;

    assign req    = READ | WRITE;
    assign accept = (state == IDLE) && req;
    assign commit = (state == ACCESS) && (cnt == 8'd0);

    // Upper bits alias onto the same word; low bits matter only for the trap.
    assign unused_addr = ^{ADDRESS[31:ADDR_BITS+2], ADDRESS[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = (ADDRESS[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign BUSYWAIT = RESET && (accept || (state == ACCESS));

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            READDATA <= 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
            MISALIGN <= 1'b0;
`endif
        end else begin
`ifdef DMEM_MISALIGN_TRAP_EN
            MISALIGN <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        if (misaligned) begin
                            state <= DONE;
`ifdef DMEM_MISALIGN_TRAP_EN
                            MISALIGN <= 1'b1;
`endif
                            if (!WRITE) READDATA <= 32'd0;
                        end else begin
                            cnt   <= 8'(LATENCY - 2);
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        if (!op_write) READDATA <= mem[idx];
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request capture; held values survive the CPU dropping its request.
    always_ff @(posedge CLK) begin
        if (RESET && accept) begin
            op_write <= WRITE;
            idx      <= ADDRESS[ADDR_BITS+1:2];
            wdata    <= WRITEDATA;
        end
    end

    // Storage is never cleared; a reset during ACCESS suppresses the commit.
    always_ff @(posedge CLK) begin
        if (RESET && commit && op_write) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases plus random traffic
// against a word-array reference model. Honors DMEM_MISALIGN_TRAP_EN.
module tb_data_mem_responder;

    localparam int LAT = 5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        BUSYWAIT;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        MISALIGN;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] last_read = 32'd0;

    data_mem_responder #(.LATENCY(LAT), .ADDR_BITS(8)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .READ(READ),
        .WRITE(WRITE),
        .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT)
`ifdef DMEM_MISALIGN_TRAP_EN
        ,
        .MISALIGN(MISALIGN)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access from the CPU side; returns in the DONE cycle (after checks).
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit hold);
        int  n;
        int  w;
        bit  mis;
        w = int'((addr >> 2) % 256);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (addr % 4) != 0;
`else
        mis = 1'b0;
`endif
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = data;
        #1;
        n = 0;
        while (BUSYWAIT === 1'b1 && n < 50) begin
            n++;
            @(negedge CLK);
            #1;
        end
        if (mis) begin
            if (!wr) last_read = 32'd0;
        end else if (wr) begin
            ref_mem[w] = data;
        end else begin
            last_read = ref_mem[w];
        end
        check("stall_cycles", 32'(n), mis ? 32'd1 : 32'(LAT));
        check("readdata", READDATA, last_read);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("misalign_done", {31'd0, MISALIGN}, {31'd0, mis});
`endif
        if (!hold) begin
            READ = 1'b0; WRITE = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a;
        RESET = 1'b0; READ = 1'b1; WRITE = 1'b0; ADDRESS = 32'd0; WRITEDATA = 32'd0;

        // Reset held with READ asserted.
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); #1;
            check("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
            check("rst_readdata", READDATA, 32'd0);
        end
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("release_busywait", {31'd0, BUSYWAIT}, 32'd1);
        READ = 1'b0;
        #1;
        check("idle_busywait", {31'd0, BUSYWAIT}, 32'd0);

        // Write then read back.
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        check("wr_rd_value", READDATA, 32'hDEADBEEF);

        // Back-to-back writes with WRITE held continuously.
        access(1'b0, 1'b1, 32'h0, 32'h11111111, 1'b1);
        access(1'b0, 1'b1, 32'h4, 32'h22222222, 1'b0);
        access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        check("b2b_first", READDATA, 32'h11111111);
        access(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        check("b2b_second", READDATA, 32'h22222222);

        // Upper address bits alias.
        access(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 1'b0);
        access(1'b1, 1'b0, 32'h000, 32'h0, 1'b0);
        check("alias", READDATA, 32'hCAFEF00D);

        // Both READ and WRITE: write only, READDATA unchanged.
        access(1'b1, 1'b1, 32'h20, 32'h5A5A5A5A, 1'b0);
        check("both_keeps_rd", READDATA, 32'hCAFEF00D);
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        // Reset during an in-flight write.
        access(1'b0, 1'b1, 32'h8, 32'h12345678, 1'b0);
        @(negedge CLK);
        WRITE = 1'b1; ADDRESS = 32'h8; WRITEDATA = 32'hAAAAAAAA;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("midrst_busywait", {31'd0, BUSYWAIT}, 32'd0);
        @(negedge CLK);
        WRITE = 1'b0; RESET = 1'b1;
        last_read = 32'd0;
        #1;
        check("midrst_readdata", READDATA, 32'd0);
        access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        check("midrst_no_commit", READDATA, 32'h12345678);

        // Misaligned read of 0x6.
        access(1'b1, 1'b0, 32'h6, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis_readdata", READDATA, 32'd0);
        @(negedge CLK); #1;
        check("mis_one_cycle", {31'd0, MISALIGN}, 32'd0);
`else
        check("unaligned_word", READDATA, 32'h22222222);
`endif

        // Random traffic over 16 words with random upper and low address bits.
        for (int i = 0; i < 16; i++)
            access(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);
        for (int i = 0; i < 40; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            a  = $urandom;
            a[9:2] = 8'($urandom_range(0, 15));
            a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            access(op != 1, op != 0, a, $urandom, $urandom_range(0, 1) == 1);
        end
        READ = 1'b0; WRITE = 1'b0;
        repeat (2) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
